systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Consumer end of the systolic array result interface. Captures each 2x2 result pulse (c11..c22 qualified by res_valid) into a small job FIFO.
- Replays each stored result as a serial element stream with a valid/ready handshake, in the order c11, c12, c21, c22.
- Sits between the array's unthrottled out_valid port and downstream logic that may stall. Exposes full/level so the job issuer can gate in_valid.

Parameters:
- DW, 9, element width; matches array output width for 4-bit operands.
- DEPTH, 2, number of whole 2x2 results buffered; any integer >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- res_valid  in  1  single-cycle pulse; c11..c22 are valid this cycle
- c11  in  DW  result element row0/col0
- c12  in  DW  result element row0/col1
- c21  in  DW  result element row1/col0
- c22  in  DW  result element row1/col1
- m_valid  out  1  stream element valid
- m_ready  in  1  downstream accepts element when m_valid & m_ready
- m_data  out  DW  current element
- m_idx  out  2  element index: 0=c11, 1=c12, 2=c21, 3=c22
- m_last  out  1  high when m_idx==3 (last element of a job)
- full  out  1  level==DEPTH
- level  out  $clog2(DEPTH+1)  jobs stored, including a partially drained head
- overflow  out  1  sticky; a result was dropped
- ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst_n low):
  - write/read pointers = 0, level = 0, element counter = 0, overflow = 0.
  - Outputs: m_valid = 0, m_idx = 0, m_last = 0, full = 0.
  - m_data is don't-care but must not be X. Storage is reset to 0.
- Storage: DEPTH entries, each 4*DW bits. Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
- Push: on a clk edge with res_valid=1 and space available, write {c11,c12,c21,c22} at wptr, advance wptr, level += 1.
- Space available when level<DEPTH, or when level==DEPTH and the head's final element (m_last & m_valid & m_ready) pops in the same cycle.
- Drop: res_valid with no space available:
  - Entry is discarded; storage, pointers and level are unchanged.
  - overflow <= 1 on the same edge.
- Output is a combinational mux of the head entry by the element counter:
  - m_valid = (level != 0).
  - m_idx = element counter; m_last = (counter==3).
- Latency: res_valid sampled at edge N with buffer empty -> m_valid=1 with m_data=c11 after edge N, i.e. one cycle. No bypass path.
- Handshake:
  - While m_valid & !m_ready, m_data, m_idx and m_last hold stable.
  - m_valid never drops without a transfer.
  - m_ready while !m_valid has no effect.
- Pop:
  - On a transfer with counter<3: counter += 1.
  - On a transfer with counter==3: counter <= 0, advance rptr, level -= 1.
  - Push and a final pop in the same cycle leave level unchanged.
- Throughput: back-to-back transfers allowed every cycle; a job drains in 4 cycles at full rate. Element 0 of the next job follows the previous m_last with no bubble.
- overflow:
  - Set by any drop.
  - Cleared by ovf_clr=1 at an edge.
  - A drop in the same cycle as ovf_clr wins: overflow stays 1.
- Width rule: data is stored and emitted unmodified. No truncation or sign handling.
- Reset mid-stream: any partially drained job is discarded, with no partial-job completion after reset.

Decomposition:
- Shared package holds:
  - localparam C_DW=9 and ELEMS_PER_JOB=4.
  - Element index constants IDX_C11..IDX_C22.
  - A typedef for the packed 4-element result word, shared with the array wrapper.
- One sub-module, result_job_fifo: a generic DEPTH-entry FIFO with level and simultaneous push/pop.
- The top level adds the element counter, the output mux and the overflow logic.

Test Plan:
- Single job, m_ready=1:
  - Stimulus: res_valid with C=[[19,22],[43,50]].
  - Response: m_data 19,22,43,50 on 4 consecutive cycles starting 1 cycle after the pulse; m_idx 0..3; m_last only on 50; level returns to 0.
- Backpressure:
  - Stimulus: same job, m_ready low for 3 cycles mid-job after element 22.
  - Response: m_data holds 22 with m_valid high; the stream resumes 43,50; no duplicates.
- Two jobs 4 cycles apart, m_ready=0 until both are captured:
  - Stimulus: results [[19,22],[43,50]] then [[2,2],[2,2]].
  - Response: level=2 and full=1; the drain yields 19,22,43,50,2,2,2,2 with no bubble between 50 and the first 2.
- Overflow (DEPTH=2, m_ready=0):
  - Stimulus: three pulses, the third being [[2,3],[4,5]].
  - Response: third is dropped; overflow=1; level=2; the drain shows only the first two jobs.
  - ovf_clr then clears overflow.
- Full with simultaneous final pop and push:
  - Stimulus: level=2, head at m_idx=3 with m_ready=1, and res_valid in the same cycle.
  - Response: push accepted, overflow stays 0, level stays 2; pointer wrap verified over 5+ jobs.
- Reset mid-stream:
  - Stimulus: assert rst_n low while m_idx=2.
  - Response: m_valid=0, level=0, overflow=0 immediately (async).
  - After release, a new job [[2,3],[4,5]] streams from m_idx=0 correctly.

Source files
------------

// File: rtl/systolic_result_drain_pkg.sv
// Shared constants and types for the systolic result drain and the array wrapper.
package systolic_result_drain_pkg;

    localparam int unsigned C_DW          = 9;
    localparam int unsigned ELEMS_PER_JOB = 4;

    // Element order on the serial stream.
    localparam logic [1:0] IDX_C11 = 2'd0;
    localparam logic [1:0] IDX_C12 = 2'd1;
    localparam logic [1:0] IDX_C21 = 2'd2;
    localparam logic [1:0] IDX_C22 = 2'd3;

    // One whole 2x2 result; c11 occupies the most significant slice.
    typedef struct packed {
        logic [C_DW-1:0] c11;
        logic [C_DW-1:0] c12;
        logic [C_DW-1:0] c21;
        logic [C_DW-1:0] c22;
    } result_word_t;

endpackage

// File: rtl/result_job_fifo.sv
// Generic DEPTH-entry FIFO with occupancy level; push and pop may happen on the same edge.
module result_job_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);

    // Next-state for pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = next_ptr(wptr_q);
        if (do_pop)  rptr_d = next_ptr(rptr_q);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Entry storage, cleared on reset so the read mux never shows X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Buffers 2x2 result pulses and replays each as a four-element valid/ready stream.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int unsigned DW    = C_DW,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         res_valid,
    input  logic [DW-1:0]                c11,
    input  logic [DW-1:0]                c12,
    input  logic [DW-1:0]                c21,
    input  logic [DW-1:0]                c22,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DW-1:0]                m_data,
    output logic [1:0]                   m_idx,
    output logic                         m_last,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    logic [1:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [4*DW-1:0] wr_word, rd_word;
    logic            fifo_empty, fifo_full;
    logic            xfer, final_pop, space, push, drop;

    assign wr_word   = {c11, c12, c21, c22};
    assign m_valid   = ~fifo_empty;
    assign xfer      = m_valid & m_ready;
    assign final_pop = xfer & (cnt_q == IDX_C22);
    assign space     = ~fifo_full | final_pop;
    assign push      = res_valid & space;
    assign drop      = res_valid & ~space;

    assign m_idx    = cnt_q;
    assign m_last   = (cnt_q == IDX_C22);
    assign full     = fifo_full;
    assign overflow = ovf_q;

    result_job_fifo #(
        .WIDTH (4 * DW),
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_word),
        .pop   (final_pop),
        .rdata (rd_word),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Select the current element of the head job.
    always_comb begin
        m_data = rd_word[3*DW +: DW];
        case (cnt_q)
            IDX_C11: m_data = rd_word[3*DW +: DW];
            IDX_C12: m_data = rd_word[2*DW +: DW];
            IDX_C21: m_data = rd_word[1*DW +: DW];
            IDX_C22: m_data = rd_word[0 +: DW];
            default: m_data = rd_word[3*DW +: DW];
        endcase
    end

    // Element counter advances per transfer and wraps with the head pop.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer) cnt_d = final_pop ? IDX_C11 : cnt_q + 2'd1;
    end

    // Sticky overflow; a drop on the clearing edge keeps it set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // Counter and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= IDX_C11;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench: directed sequences, a vector table and random traffic vs. a queue model.
module tb_systolic_result_drain;

    localparam int unsigned DW    = 9;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    typedef logic [3:0][DW-1:0] job_t;  // [0]=c11 .. [3]=c22, i.e. stream order
    typedef struct packed {
        job_t job;
        job_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          res_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic          m_valid, m_last, full, overflow;
    logic [DW-1:0] m_data;
    logic [1:0]    m_idx;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of whole jobs, the position inside the head, and the sticky flag.
    job_t mq[$];
    int   mcnt = 0;
    bit   movf = 1'b0;

    systolic_result_drain #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .c11       (c11),
        .c12       (c12),
        .c21       (c21),
        .c22       (c22),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic job_t mk(input int a, input int b, input int c, input int d);
        job_t j;
        j[0] = DW'(a);
        j[1] = DW'(b);
        j[2] = DW'(c);
        j[3] = DW'(d);
        return j;
    endfunction

    task automatic check_model();
        check("model m_valid", m_valid, mq.size() != 0);
        check("model level", level, mq.size());
        check("model full", full, mq.size() == DEPTH);
        check("model overflow", overflow, movf);
        check("model m_idx", m_idx, mcnt);
        check("model m_last", m_last, mcnt == 3);
        if (mq.size() != 0) check("model m_data", m_data, mq[0][mcnt]);
    endtask

    // One clock: model follows the rules on the edge, pulses are dropped, outputs checked at negedge.
    task automatic cycle();
        bit   fire, last_pop, space;
        job_t j;
        fire     = (mq.size() != 0) && m_ready;
        last_pop = fire && (mcnt == 3);
        space    = (mq.size() < DEPTH) || last_pop;
        j        = {c22, c21, c12, c11};
        @(posedge clk);
        if (fire) begin
            if (last_pop) begin
                mcnt = 0;
                void'(mq.pop_front());
            end else begin
                mcnt++;
            end
        end
        if (res_valid && space) mq.push_back(j);
        if (res_valid && !space) movf = 1'b1;
        else if (ovf_clr)        movf = 1'b0;
        #1;
        res_valid = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        check_model();
    endtask

    task automatic pulse(input job_t j);
        c11 = j[0];
        c12 = j[1];
        c21 = j[2];
        c22 = j[3];
        res_valid = 1'b1;
        cycle();
    endtask

    // Expects job j on the stream with m_ready=1, four back-to-back elements.
    task automatic expect_job(input string name, input job_t j);
        for (int e = 0; e < 4; e++) begin
            check({name, " m_valid"}, m_valid, 1);
            check({name, " m_data"}, m_data, j[e]);
            check({name, " m_idx"}, m_idx, e);
            check({name, " m_last"}, m_last, e == 3);
            cycle();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        mq.delete();
        mcnt = 0;
        movf = 1'b0;
        #1;
        check("reset m_valid", m_valid, 0);
        check("reset level", level, 0);
        check("reset overflow", overflow, 0);
        check("reset full", full, 0);
        check("reset m_idx", m_idx, 0);
        check("reset m_last", m_last, 0);
        check("reset m_data known", $isunknown(m_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[4];
    job_t ja, jb, jc;

    initial begin
        ja = mk(19, 22, 43, 50);
        jb = mk(2, 2, 2, 2);
        jc = mk(2, 3, 4, 5);
        vecs[0] = '{job: mk(19, 22, 43, 50),      exp: mk(19, 22, 43, 50)};
        vecs[1] = '{job: mk(0, 511, 256, 1),      exp: mk(0, 511, 256, 1)};
        vecs[2] = '{job: mk(2, 3, 4, 5),          exp: mk(2, 3, 4, 5)};
        vecs[3] = '{job: mk('h155, 'h0aa, 'h1ff, 'h100), exp: mk(341, 170, 511, 256)};

        do_reset();
        @(negedge clk);

        // Single jobs at full rate: data one cycle after the pulse, unmodified.
        m_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            pulse(vecs[v].job);
            expect_job("table", vecs[v].exp);
            check("table drained level", level, 0);
        end

        // Backpressure after element 22.
        pulse(ja);
        check("bp first", m_data, 19);
        cycle();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp hold data", m_data, 22);
            check("bp hold valid", m_valid, 1);
            check("bp hold idx", m_idx, 1);
            cycle();
        end
        m_ready = 1'b1;
        check("bp resume data", m_data, 22);
        cycle();
        check("bp 43", m_data, 43);
        cycle();
        check("bp 50", m_data, 50);
        check("bp last", m_last, 1);
        cycle();
        check("bp empty", m_valid, 0);

        // Two jobs four cycles apart, drained without a bubble.
        m_ready = 1'b0;
        pulse(ja);
        cycle();
        cycle();
        cycle();
        pulse(jb);
        check("two level", level, 2);
        check("two full", full, 1);
        m_ready = 1'b1;
        expect_job("two A", ja);
        expect_job("two B", jb);
        check("two empty", m_valid, 0);

        // Overflow: third pulse dropped.
        m_ready = 1'b0;
        pulse(ja);
        pulse(jb);
        pulse(jc);
        check("ovf flag", overflow, 1);
        check("ovf level", level, 2);
        m_ready = 1'b1;
        expect_job("ovf A", ja);
        expect_job("ovf B", jb);
        check("ovf third dropped", m_valid, 0);
        ovf_clr = 1'b1;
        cycle();
        check("ovf cleared", overflow, 0);

        // Drop on the same edge as ovf_clr keeps overflow set.
        m_ready = 1'b0;
        pulse(ja);
        pulse(jb);
        ovf_clr = 1'b1;
        pulse(jc);
        check("drop beats clr", overflow, 1);
        ovf_clr = 1'b1;
        cycle();
        check("clr after drop", overflow, 0);
        m_ready = 1'b1;
        expect_job("dc A", ja);
        expect_job("dc B", jb);

        // Full FIFO, final pop and push on the same edge.
        m_ready = 1'b0;
        pulse(ja);
        pulse(jb);
        m_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        check("fp idx3", m_idx, 3);
        check("fp level before", level, 2);
        pulse(jc);
        check("fp level after", level, 2);
        check("fp no overflow", overflow, 0);
        expect_job("fp B", jb);
        expect_job("fp C", jc);
        check("fp empty", m_valid, 0);

        // Random traffic against the model; many pointer wraps.
        for (int n = 0; n < 500; n++) begin
            c11 = DW'($urandom);
            c12 = DW'($urandom);
            c21 = DW'($urandom);
            c22 = DW'($urandom);
            res_valid = ($urandom_range(0, 2) == 0);
            m_ready   = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            cycle();
        end
        m_ready = 1'b1;
        for (int n = 0; n < 12; n++) cycle();
        check("rand drained", m_valid, 0);

        // Reset in the middle of a job.
        ovf_clr = 1'b1;
        cycle();
        m_ready = 1'b0;
        pulse(ja);
        pulse(jb);
        pulse(jc);
        check("mid ovf set", overflow, 1);
        m_ready = 1'b1;
        cycle();
        cycle();
        check("mid idx2", m_idx, 2);
        #2;
        do_reset();
        @(negedge clk);
        check("post reset valid", m_valid, 0);
        m_ready = 1'b1;
        pulse(jc);
        expect_job("post reset C", jc);
        check("post reset empty", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
